// File: rtl/mip_result_writer.sv
// rtl/mip_result_writer.sv - buffers one burst of MIP results and writes it out through a DataMover S2MM channel
module mip_result_writer #(
  parameter int BURST_BEATS = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         io_ctrl_start_valid,
  output logic         io_ctrl_start_ready,
  input  logic [31:0]  io_ctrl_base_addr,
  input  logic [15:0]  io_ctrl_num_bursts,
  output logic         io_ctrl_done,
  output logic         io_ctrl_error,
  input  logic [127:0] io_s_result_tdata,
  input  logic         io_s_result_tvalid,
  output logic         io_s_result_tready,
  output logic [71:0]  io_m_axis_s2mm_cmd_tdata,
  output logic         io_m_axis_s2mm_cmd_tvalid,
  input  logic         io_m_axis_s2mm_cmd_tready,
  output logic [127:0] io_m_axis_s2mm_tdata,
  output logic [15:0]  io_m_axis_s2mm_tkeep,
  output logic         io_m_axis_s2mm_tlast,
  output logic         io_m_axis_s2mm_tvalid,
  input  logic         io_m_axis_s2mm_tready,
  input  logic [7:0]   io_s_axis_s2mm_sts_tdata,
  input  logic         io_s_axis_s2mm_sts_tvalid,
  output logic         io_s_axis_s2mm_sts_tready
);

  localparam int              IW          = $clog2(BURST_BEATS);
  localparam logic [IW-1:0]   LAST_IDX    = IW'(BURST_BEATS - 1);
  localparam logic [IW-1:0]   PRELAST_IDX = IW'(BURST_BEATS - 2);
  localparam logic [22:0]     BTT         = 23'(BURST_BEATS * 16);
  localparam logic [31:0]     BURST_BYTES = 32'(BURST_BEATS * 16);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_CMD,
    S_DATA,
    S_STS
  } state_t;

  state_t          state_q;
  logic [31:0]     addr_q;
  logic [15:0]     num_bursts_q;
  logic [15:0]     burst_idx_q;
  logic [IW-1:0]   fill_cnt_q;
  logic [IW-1:0]   rd_idx_q;
  logic            start_ready_q;
  logic            result_tready_q;
  logic            cmd_tvalid_q;
  logic            tvalid_q;
  logic            tlast_q;
  logic            sts_tready_q;
  logic            done_q;
  logic            error_q;
  logic [127:0]    buf_q [BURST_BEATS];

  logic            start_hs;
  logic            fill_hs;
  logic            cmd_hs;
  logic            data_hs;
  logic            sts_hs;
  logic            sts_bad;
  logic            last_burst;

  assign start_hs   = start_ready_q   & io_ctrl_start_valid;
  assign fill_hs    = result_tready_q & io_s_result_tvalid;
  assign cmd_hs     = cmd_tvalid_q    & io_m_axis_s2mm_cmd_tready;
  assign data_hs    = tvalid_q        & io_m_axis_s2mm_tready;
  assign sts_hs     = sts_tready_q    & io_s_axis_s2mm_sts_tvalid;
  assign last_burst = (burst_idx_q == (num_bursts_q - 16'd1));

  // Status is bad on a non-OKAY response, any internal/decode/slave error bit, or a tag that is not ours
  assign sts_bad = ~io_s_axis_s2mm_sts_tdata[7]
                 | (|io_s_axis_s2mm_sts_tdata[6:4])
                 | (io_s_axis_s2mm_sts_tdata[3:0] != burst_idx_q[3:0]);

  // Job sequencer: every handshake output is a register updated together with the state
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      num_bursts_q    <= '0;
      burst_idx_q     <= '0;
      fill_cnt_q      <= '0;
      rd_idx_q        <= '0;
      start_ready_q   <= 1'b1;
      result_tready_q <= 1'b0;
      cmd_tvalid_q    <= 1'b0;
      tvalid_q        <= 1'b0;
      tlast_q         <= 1'b0;
      sts_tready_q    <= 1'b0;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_hs) begin
            addr_q       <= io_ctrl_base_addr;
            num_bursts_q <= io_ctrl_num_bursts;
            burst_idx_q  <= '0;
            fill_cnt_q   <= '0;
            rd_idx_q     <= '0;
            error_q      <= 1'b0;
            if (io_ctrl_num_bursts == 16'd0) begin
              done_q <= 1'b1;
            end else begin
              state_q         <= S_FILL;
              start_ready_q   <= 1'b0;
              result_tready_q <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (fill_hs) begin
            fill_cnt_q <= fill_cnt_q + IW'(1);
            if (fill_cnt_q == LAST_IDX) begin
              fill_cnt_q      <= '0;
              state_q         <= S_CMD;
              result_tready_q <= 1'b0;
              cmd_tvalid_q    <= 1'b1;
            end
          end
        end
        S_CMD: begin
          if (cmd_hs) begin
            state_q      <= S_DATA;
            cmd_tvalid_q <= 1'b0;
            tvalid_q     <= 1'b1;
            tlast_q      <= 1'b0;
          end
        end
        S_DATA: begin
          if (data_hs) begin
            if (rd_idx_q == LAST_IDX) begin
              rd_idx_q     <= '0;
              tvalid_q     <= 1'b0;
              tlast_q      <= 1'b0;
              sts_tready_q <= 1'b1;
              state_q      <= S_STS;
            end else begin
              rd_idx_q <= rd_idx_q + IW'(1);
              tlast_q  <= (rd_idx_q == PRELAST_IDX);
            end
          end
        end
        S_STS: begin
          if (sts_hs) begin
            if (sts_bad) begin
              error_q <= 1'b1;
            end
            sts_tready_q <= 1'b0;
            if (last_burst) begin
              done_q        <= 1'b1;
              start_ready_q <= 1'b1;
              state_q       <= S_IDLE;
            end else begin
              burst_idx_q     <= burst_idx_q + 16'd1;
              addr_q          <= addr_q + BURST_BYTES;
              result_tready_q <= 1'b1;
              state_q         <= S_FILL;
            end
          end
        end
        default: begin
          state_q         <= S_IDLE;
          start_ready_q   <= 1'b1;
          result_tready_q <= 1'b0;
          cmd_tvalid_q    <= 1'b0;
          tvalid_q        <= 1'b0;
          tlast_q         <= 1'b0;
          sts_tready_q    <= 1'b0;
        end
      endcase
    end
  end

  // Burst buffer: captures accepted result beats; deliberately not cleared by reset
  always_ff @(posedge clock) begin
    if (!reset && state_q == S_FILL && fill_hs) begin
      buf_q[fill_cnt_q] <= io_s_result_tdata;
    end
  end

  assign io_ctrl_start_ready       = start_ready_q;
  assign io_ctrl_done              = done_q;
  assign io_ctrl_error             = error_q;
  assign io_s_result_tready        = result_tready_q;
  assign io_m_axis_s2mm_cmd_tvalid = cmd_tvalid_q;
  assign io_m_axis_s2mm_cmd_tdata  = {4'b0000, burst_idx_q[3:0], addr_q,
                                      1'b0, 1'b1, 6'b000000, 1'b1, BTT};
  assign io_m_axis_s2mm_tvalid     = tvalid_q;
  assign io_m_axis_s2mm_tlast      = tlast_q;
  assign io_m_axis_s2mm_tkeep      = 16'hFFFF;
  assign io_m_axis_s2mm_tdata      = buf_q[rd_idx_q];
  assign io_s_axis_s2mm_sts_tready = sts_tready_q;

endmodule

// File: tb/tb_mip_result_writer.sv
// tb/tb_mip_result_writer.sv - randomized self-checking bench for mip_result_writer
module tb_mip_result_writer;

  localparam int BB = 16;

  logic         clock = 1'b0;
  logic         reset;
  logic         io_ctrl_start_valid;
  logic         io_ctrl_start_ready;
  logic [31:0]  io_ctrl_base_addr;
  logic [15:0]  io_ctrl_num_bursts;
  logic         io_ctrl_done;
  logic         io_ctrl_error;
  logic [127:0] io_s_result_tdata;
  logic         io_s_result_tvalid;
  logic         io_s_result_tready;
  logic [71:0]  io_m_axis_s2mm_cmd_tdata;
  logic         io_m_axis_s2mm_cmd_tvalid;
  logic         io_m_axis_s2mm_cmd_tready;
  logic [127:0] io_m_axis_s2mm_tdata;
  logic [15:0]  io_m_axis_s2mm_tkeep;
  logic         io_m_axis_s2mm_tlast;
  logic         io_m_axis_s2mm_tvalid;
  logic         io_m_axis_s2mm_tready;
  logic [7:0]   io_s_axis_s2mm_sts_tdata;
  logic         io_s_axis_s2mm_sts_tvalid;
  logic         io_s_axis_s2mm_sts_tready;

  int n_cmp = 0;
  int n_err = 0;

  mip_result_writer #(.BURST_BEATS(BB)) dut (
    .clock                     (clock),
    .reset                     (reset),
    .io_ctrl_start_valid       (io_ctrl_start_valid),
    .io_ctrl_start_ready       (io_ctrl_start_ready),
    .io_ctrl_base_addr         (io_ctrl_base_addr),
    .io_ctrl_num_bursts        (io_ctrl_num_bursts),
    .io_ctrl_done              (io_ctrl_done),
    .io_ctrl_error             (io_ctrl_error),
    .io_s_result_tdata         (io_s_result_tdata),
    .io_s_result_tvalid        (io_s_result_tvalid),
    .io_s_result_tready        (io_s_result_tready),
    .io_m_axis_s2mm_cmd_tdata  (io_m_axis_s2mm_cmd_tdata),
    .io_m_axis_s2mm_cmd_tvalid (io_m_axis_s2mm_cmd_tvalid),
    .io_m_axis_s2mm_cmd_tready (io_m_axis_s2mm_cmd_tready),
    .io_m_axis_s2mm_tdata      (io_m_axis_s2mm_tdata),
    .io_m_axis_s2mm_tkeep      (io_m_axis_s2mm_tkeep),
    .io_m_axis_s2mm_tlast      (io_m_axis_s2mm_tlast),
    .io_m_axis_s2mm_tvalid     (io_m_axis_s2mm_tvalid),
    .io_m_axis_s2mm_tready     (io_m_axis_s2mm_tready),
    .io_s_axis_s2mm_sts_tdata  (io_s_axis_s2mm_sts_tdata),
    .io_s_axis_s2mm_sts_tvalid (io_s_axis_s2mm_sts_tvalid),
    .io_s_axis_s2mm_sts_tready (io_s_axis_s2mm_sts_tready)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    io_ctrl_start_valid       = 1'b0;
    io_ctrl_base_addr         = '0;
    io_ctrl_num_bursts        = '0;
    io_s_result_tdata         = '0;
    io_s_result_tvalid        = 1'b0;
    io_m_axis_s2mm_cmd_tready = 1'b0;
    io_m_axis_s2mm_tready     = 1'b0;
    io_s_axis_s2mm_sts_tdata  = '0;
    io_s_axis_s2mm_sts_tvalid = 1'b0;
  endtask

  // Expected DataMover command for burst b of a job starting at base
  function automatic logic [71:0] exp_cmd(input logic [31:0] base, input int b);
    logic [31:0] saddr;
    logic [3:0]  tag;
    saddr = base + 32'(b * BB * 16);
    tag   = 4'(b % 16);
    return {4'h0, tag, saddr, 1'b0, 1'b1, 6'd0, 1'b1, 23'(BB * 16)};
  endfunction

  // Runs one job cycle by cycle; inputs change on the falling edge, handshakes are decided there too.
  task automatic run_job(input logic [31:0] base, input int n, input bit stall, input bit incr_data,
                         input int bad_burst, input logic [7:0] bad_sts, input int abort_beat);
    logic [127:0] res_q[$];
    logic [127:0] exp_data[$];
    logic [127:0] got_data[$];
    logic         got_last[$];
    logic [71:0]  got_cmd[$];
    logic [7:0]   sts_q[$];
    logic [71:0]  prev_cmd;
    logic [127:0] prev_dat;
    logic         prev_last;
    logic [7:0]   s;
    bit prev_cmd_stall = 0, prev_dat_stall = 0, started = 0, exp_err = 0;
    int cyc = 0, start_cyc = -1, sts_hs_cyc = -1, done_cyc = -1, dcnt = 0;
    int beats = 0, sts_made = 0, sts_cnt = 0, sts_delay = 0;

    for (int i = 0; i < n * BB; i++) begin
      logic [127:0] v;
      v = incr_data ? 128'(i) : {$urandom, $urandom, $urandom, $urandom};
      res_q.push_back(v);
      exp_data.push_back(v);
    end

    while (!(dcnt > 0 && cyc >= done_cyc + 2) && cyc < 20000) begin
      @(negedge clock);
      cyc++;
      if (prev_cmd_stall) begin
        check("cmd_hold_valid", io_m_axis_s2mm_cmd_tvalid, 1'b1);
        check("cmd_hold_data", io_m_axis_s2mm_cmd_tdata, prev_cmd);
      end
      if (prev_dat_stall) begin
        check("dat_hold_valid", io_m_axis_s2mm_tvalid, 1'b1);
        check("dat_hold_data", io_m_axis_s2mm_tdata, prev_dat);
        check("dat_hold_last", io_m_axis_s2mm_tlast, prev_last);
      end
      if (started && cyc == start_cyc + 1)
        check("err_clear_on_start", io_ctrl_error, 1'b0);
      if (io_ctrl_done) begin
        dcnt++;
        if (dcnt == 1) done_cyc = cyc;
      end
      if (abort_beat >= 0 && beats == abort_beat && io_m_axis_s2mm_tvalid) begin
        idle_inputs();
        reset = 1'b1;
        @(negedge clock);
        check("abort_tvalid", io_m_axis_s2mm_tvalid, 1'b0);
        check("abort_start_ready", io_ctrl_start_ready, 1'b1);
        check("abort_done", io_ctrl_done, 1'b0);
        reset = 1'b0;
        return;
      end

      if (!started) begin
        io_ctrl_start_valid = 1'b1;
        io_ctrl_base_addr   = base;
        io_ctrl_num_bursts  = 16'(n);
        if (io_ctrl_start_ready) begin
          started   = 1;
          start_cyc = cyc;
        end
      end else begin
        io_ctrl_start_valid = !io_ctrl_start_ready && ($urandom_range(3) == 0);
        io_ctrl_base_addr   = $urandom;
        io_ctrl_num_bursts  = 16'($urandom);
      end

      io_s_result_tvalid = (res_q.size() > 0) && (!stall || $urandom_range(1) == 1);
      io_s_result_tdata  = io_s_result_tvalid ? res_q[0] : {$urandom, $urandom, $urandom, $urandom};
      if (io_s_result_tvalid && io_s_result_tready) void'(res_q.pop_front());

      io_m_axis_s2mm_cmd_tready = !stall || $urandom_range(1) == 1;
      if (io_m_axis_s2mm_cmd_tvalid && io_m_axis_s2mm_cmd_tready) got_cmd.push_back(io_m_axis_s2mm_cmd_tdata);
      prev_cmd_stall = io_m_axis_s2mm_cmd_tvalid && !io_m_axis_s2mm_cmd_tready;
      prev_cmd       = io_m_axis_s2mm_cmd_tdata;

      io_s_axis_s2mm_sts_tvalid = (sts_q.size() > 0) && (sts_delay == 0);
      io_s_axis_s2mm_sts_tdata  = (sts_q.size() > 0) ? sts_q[0] : 8'h00;
      if (sts_q.size() > 0 && sts_delay > 0) sts_delay--;
      if (io_s_axis_s2mm_sts_tvalid && io_s_axis_s2mm_sts_tready) begin
        void'(sts_q.pop_front());
        sts_hs_cyc = cyc;
        sts_cnt++;
      end

      io_m_axis_s2mm_tready = !stall || $urandom_range(1) == 1;
      if (io_m_axis_s2mm_tvalid && io_m_axis_s2mm_tready) begin
        got_data.push_back(io_m_axis_s2mm_tdata);
        got_last.push_back(io_m_axis_s2mm_tlast);
        beats++;
        if (io_m_axis_s2mm_tlast) begin
          s = (sts_made == bad_burst) ? bad_sts : {1'b1, 3'b000, 4'(sts_made % 16)};
          if (!s[7] || s[6:4] != 3'b000 || s[3:0] != 4'(sts_made % 16)) exp_err = 1;
          sts_q.push_back(s);
          sts_made++;
          sts_delay = stall ? $urandom_range(3) : 0;
        end
      end
      prev_dat_stall = io_m_axis_s2mm_tvalid && !io_m_axis_s2mm_tready;
      prev_dat       = io_m_axis_s2mm_tdata;
      prev_last      = io_m_axis_s2mm_tlast;
    end

    idle_inputs();
    check("job_finished", 32'(dcnt > 0), 32'd1);
    check("done_count", 32'(dcnt), 32'd1);
    check("done_latency", 32'(done_cyc), 32'((n == 0 ? start_cyc : sts_hs_cyc) + 1));
    check("error_final", io_ctrl_error, exp_err);
    check("sts_consumed", 32'(sts_cnt), 32'(n));
    check("cmd_count", 32'(got_cmd.size()), 32'(n));
    for (int b = 0; b < got_cmd.size() && b < n; b++)
      check($sformatf("cmd[%0d]", b), got_cmd[b], exp_cmd(base, b));
    check("beat_count", 32'(got_data.size()), 32'(n * BB));
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      check($sformatf("data[%0d]", i), got_data[i], exp_data[i]);
      check($sformatf("tlast[%0d]", i), got_last[i], (i % BB) == BB - 1);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clock);
    check("rst_start_ready", io_ctrl_start_ready, 1'b1);
    check("rst_done", io_ctrl_done, 1'b0);
    check("rst_error", io_ctrl_error, 1'b0);
    check("rst_result_tready", io_s_result_tready, 1'b0);
    check("rst_cmd_tvalid", io_m_axis_s2mm_cmd_tvalid, 1'b0);
    check("rst_tvalid", io_m_axis_s2mm_tvalid, 1'b0);
    check("rst_tlast", io_m_axis_s2mm_tlast, 1'b0);
    check("rst_sts_tready", io_s_axis_s2mm_sts_tready, 1'b0);
    check("tkeep", io_m_axis_s2mm_tkeep, 16'hFFFF);
    reset = 1'b0;

    run_job(32'h1000_0000, 1, 0, 1, -1, 8'h00, -1);
    run_job(32'h1000_0000, 3, 0, 0, -1, 8'h00, -1);
    run_job($urandom, 4, 1, 0, -1, 8'h00, -1);
    run_job($urandom, 18, 1, 0, -1, 8'h00, -1);
    run_job(32'h2000_0000, 2, 0, 0, 0, 8'hC0, -1);
    run_job(32'h2100_0000, 2, 1, 0, 1, 8'h80, -1);
    run_job(32'h3000_0000, 0, 0, 0, -1, 8'h00, -1);
    run_job(32'hFFFF_FF80, 2, 1, 0, -1, 8'h00, -1);
    run_job(32'h4000_0000, 2, 0, 0, -1, 8'h00, 5);
    run_job(32'h5000_0000, 2, 1, 0, -1, 8'h00, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mip_result_writer.md
MIP_RESULT_WRITER -- requirements
Module: mip_result_writer

Interface
REQ-001 Parameter BURST_BEATS, 16, number of 128-bit beats per S2MM burst; power of two, 2..64.
REQ-002 clock  in  1  single clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 io_ctrl_start_valid  in  1  job start request.
REQ-005 io_ctrl_start_ready  out  1  high only in IDLE.
REQ-006 io_ctrl_base_addr  in  32  byte address of first burst; sampled on start handshake.
REQ-007 io_ctrl_num_bursts  in  16  bursts in job; sampled on start handshake.
REQ-008 io_ctrl_done  out  1  one-cycle pulse at job completion.
REQ-009 io_ctrl_error  out  1  sticky status error; cleared on next start handshake.
REQ-010 io_s_result_tdata / _tvalid / _tready  in 128 / in 1 / out 1  MIP result stream input.
REQ-011 io_m_axis_s2mm_cmd_tdata / _tvalid / _tready  out 72 / out 1 / in 1  DataMover S2MM command.
REQ-012 io_m_axis_s2mm_tdata / _tkeep / _tlast / _tvalid / _tready  out 128 / out 16 / out 1 / out 1 / in 1  S2MM write data.
REQ-013 io_s_axis_s2mm_sts_tdata / _tvalid / _tready  in 8 / in 1 / out 1  S2MM status.

Function
REQ-014 FSM states IDLE, FILL, CMD, DATA, STS; all outputs are decoded from registered state/counters, with no input-to-output combinational path except none.
REQ-015 IDLE: start_ready=1; on start handshake, latch base_addr and num_bursts, clear burst_idx, fill_cnt, rd_idx and error; go to FILL, or stay IDLE and pulse done next cycle if num_bursts==0.
REQ-016 FILL: result_tready=1; each accepted beat is written to buffer[fill_cnt] and fill_cnt increments; on the accept of beat BURST_BEATS-1, go to CMD with fill_cnt reset to 0.
REQ-017 The buffer holds exactly BURST_BEATS x 128 bits; result_tready=0 in every state other than FILL.
REQ-018 CMD: cmd_tvalid=1; cmd_tdata stays stable until cmd_tready; on handshake go to DATA.
REQ-019 Command fields: [22:0] BTT=BURST_BEATS*16; [23] TYPE=1; [29:24] DSA=0; [30] EOF=1; [31] DRR=0; [63:32] SADDR=base_addr+burst_idx*BURST_BEATS*16, truncated mod 2^32; [67:64] TAG=burst_idx[3:0]; [71:68]=0.
REQ-020 DATA: tvalid=1; tdata=buffer[rd_idx]; tkeep=16'hFFFF; tlast=1 only when rd_idx==BURST_BEATS-1; rd_idx advances only on tvalid&tready.
REQ-021 On the tlast handshake, go to STS with rd_idx reset to 0; outputs stay stable while tready is low.
REQ-022 STS: sts_tready=1; on sts_tvalid, set error if bit7 (OKAY)==0, any of bits[6:4]==1, or bits[3:0]!=burst_idx[3:0].
REQ-023 On the status handshake, if burst_idx==num_bursts-1, pulse done for one cycle and go to IDLE; otherwise increment burst_idx and go to FILL.
REQ-024 An error does not abort the job; all num_bursts bursts are still written.
REQ-025 burst_idx is 16 bits; TAG wraps every 16 bursts.
REQ-026 Status beats arriving outside STS are not accepted (sts_tready=0) and are not lost.
REQ-027 Start requests outside IDLE are ignored; start_ready=0.

Reset
REQ-028 While reset is high, on every edge: state=IDLE; all counters, burst_idx, error and done=0.
REQ-029 Reset outputs: start_ready=1; done, error, result_tready, cmd_tvalid, tvalid, tlast and sts_tready=0; cmd_tdata and tdata are don't-care.
REQ-030 Reset asserted mid-job abandons the burst: no done pulse; buffer contents are not cleared; the next start begins a fresh job.

Verification
REQ-031 base=0x1000_0000, num_bursts=1, 16 beats of incrementing data, all readies high, status 0x80 -> one cmd with SADDR=0x1000_0000, BTT=256, TAG=0; 16 data beats in order, tlast on the 16th; done pulse; error=0.
REQ-032 num_bursts=3 -> SADDR values 0x1000_0000, 0x1000_0100, 0x1000_0200; TAGs 0,1,2; exactly one done pulse, after the third status.
REQ-033 Random cmd_tready/tready/result_tvalid stalls (50%) -> identical output data sequence; cmd_tdata/tdata stable while valid&!ready.
REQ-034 Status 0xC0 (SLVERR) on burst 0 of 2 -> error=1 held; burst 1 still issued; done pulses; next start clears error.
REQ-035 num_bursts=0 -> no cmd; done pulses once, one cycle after the start handshake. base=0xFFFF_FF80 with num_bursts=2 -> second SADDR=0x0000_0080 (wrap).
REQ-036 Reset asserted during DATA beat 5 -> next cycle tvalid=0, start_ready=1, no done; a new job then completes normally.
